// File: rtl/msg_scroller_v2.sv
// msg_scroller_v2 -- message scroller for a 7-row column-driven LED/scope display.
// Message words are written into a circular store and played back as a stream of
// 8-bit display columns. A word is either a raw 6-bit column (bit6=0) or a
// character code (bit6=1) rendered as 8 columns through the 5x7 glyph ROM.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      write wr_data into the store (IDLE only)
//   wr_data    message word: bit6=1 char code in [5:0], bit6=0 raw column in [5:0]
//   clear      empty the store (IDLE only, wins over wr_en)
//   play       level: high requests playback, low aborts / returns to IDLE
//   loop       sampled at each end of message: 1 restarts, 0 finishes
//   hold       each column is held for hold+1 cycles
//   col        current display column, bit0 = top row (0 outside PLAY)
//   col_valid  one-cycle pulse on the first cycle of each column
//   busy       high in PLAY
//   done       high in DONE
//   length     number of stored words
module msg_scroller_v2 #(
  parameter int WORD_COUNT = 20,
  parameter int HOLD_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [6:0]                        wr_data,
  input  logic                              clear,
  input  logic                              play,
  input  logic                              loop,
  input  logic [HOLD_W-1:0]                 hold,
  output logic [7:0]                        col,
  output logic                              col_valid,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(WORD_COUNT+1)-1:0]   length
);

  localparam int PW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int LW = $clog2(WORD_COUNT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [6:0]        mem [WORD_COUNT];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     old_ptr;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     word_idx;
  logic [2:0]        gidx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_q;

  logic [LW:0]       rd_sum;
  logic [PW-1:0]     rd_ptr;
  logic [6:0]        cur_word;
  logic [7:0]        slot_col;
  logic              last_slot;
  logic              last_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WORD_COUNT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Each glyph is packed as 8 column bytes, column 0 in the most significant byte.
  function automatic logic [7:0] glyph(input logic [5:0] code, input logic [2:0] idx);
    logic [63:0] g;
    logic [63:0] sh;
    case (code)
      6'h10: g = 64'h00_3E_61_51_49_45_3E_00; // 0
      6'h11: g = 64'h00_00_42_7F_40_00_00_00; // 1
      6'h12: g = 64'h00_62_51_51_49_49_46_00; // 2
      6'h13: g = 64'h00_22_41_49_49_49_36_00; // 3
      6'h14: g = 64'h00_18_14_12_11_7F_10_00; // 4
      6'h15: g = 64'h00_27_45_45_45_45_39_00; // 5
      6'h16: g = 64'h00_3E_49_49_49_49_32_00; // 6
      6'h17: g = 64'h00_01_01_71_09_05_03_00; // 7
      6'h18: g = 64'h00_36_49_49_49_49_36_00; // 8
      6'h19: g = 64'h00_26_49_49_49_49_3E_00; // 9
      6'h21: g = 64'h00_7C_12_11_11_12_7C_00; // A
      6'h22: g = 64'h00_7F_49_49_49_49_36_00; // B
      6'h23: g = 64'h00_3E_41_41_41_41_22_00; // C
      6'h24: g = 64'h00_7F_41_41_41_22_1C_00; // D
      6'h25: g = 64'h00_7F_49_49_49_49_41_00; // E
      6'h26: g = 64'h00_7F_09_09_09_09_01_00; // F
      6'h27: g = 64'h00_3E_41_41_49_49_3A_00; // G
      6'h28: g = 64'h00_7F_08_08_08_08_7F_00; // H
      6'h29: g = 64'h00_00_41_7F_41_00_00_00; // I
      6'h2A: g = 64'h00_20_40_41_41_3F_01_00; // J
      6'h2B: g = 64'h00_7F_08_08_14_22_41_40; // K
      6'h2C: g = 64'h00_7F_40_40_40_40_40_00; // L
      6'h2D: g = 64'h00_7F_02_04_08_04_02_7F; // M
      6'h2E: g = 64'h00_7F_02_04_08_10_7F_00; // N
      6'h2F: g = 64'h00_3E_41_41_41_41_3E_00; // O
      6'h30: g = 64'h00_7F_09_09_09_09_06_00; // P
      6'h31: g = 64'h00_3E_41_41_51_21_5E_40; // Q
      6'h32: g = 64'h00_7F_09_09_19_29_46_00; // R
      6'h33: g = 64'h00_26_49_49_49_49_32_00; // S
      6'h34: g = 64'h00_01_01_01_7F_01_01_01; // T
      6'h35: g = 64'h00_3F_40_40_40_40_3F_00; // U
      6'h36: g = 64'h00_07_18_20_40_20_18_07; // V
      6'h37: g = 64'h00_7F_20_10_08_10_20_7F; // W
      6'h38: g = 64'h00_41_22_14_08_14_22_41; // X
      6'h39: g = 64'h00_01_02_04_78_04_02_01; // Y
      6'h3A: g = 64'h00_41_61_51_49_45_43_41; // Z
      default: g = '0;
    endcase
    sh = g >> {3'd7 - idx, 3'b000};
    return sh[7:0];
  endfunction

  // Read address = oldest + word offset, wrapped modulo the store depth.
  always_comb begin
    rd_sum = (LW+1)'(old_ptr) + (LW+1)'(word_idx);
    if (rd_sum >= (LW+1)'(WORD_COUNT)) begin
      rd_sum = rd_sum - (LW+1)'(WORD_COUNT);
    end
    rd_ptr = PW'(rd_sum);
  end

  assign cur_word  = mem[rd_ptr];
  assign slot_col  = cur_word[6] ? glyph(cur_word[5:0], gidx) : {1'b0, cur_word[5:0], 1'b0};
  assign last_slot = !cur_word[6] || (gidx == 3'd7);
  assign last_word = (word_idx == len_q - 1'b1);

  assign col       = (state == S_PLAY) ? slot_col : '0;
  assign col_valid = (state == S_PLAY) && start_q;
  assign busy      = (state == S_PLAY);
  assign done      = (state == S_DONE);
  assign length    = len_q;

  // Store contents need no reset; only pointers and length define validity.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && wr_en && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      old_ptr  <= '0;
      len_q    <= '0;
      word_idx <= '0;
      gidx     <= '0;
      hold_cnt <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear) begin
            len_q   <= '0;
            wr_ptr  <= '0;
            old_ptr <= '0;
          end else if (wr_en) begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (len_q == LW'(WORD_COUNT)) begin
              old_ptr <= ptr_inc(old_ptr);
            end else begin
              len_q <= len_q + 1'b1;
            end
          end
          if (play) begin
            // A simultaneous clear leaves nothing to play, so treat it as empty.
            if (len_q != '0 && !clear) begin
              state    <= S_PLAY;
              word_idx <= '0;
              gidx     <= '0;
              hold_cnt <= hold;
              start_q  <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_PLAY: begin
          if (!play) begin
            state <= S_IDLE;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            hold_cnt <= hold;
            start_q  <= 1'b1;
            if (!last_slot) begin
              gidx <= gidx + 1'b1;
            end else begin
              gidx <= '0;
              if (!last_word) begin
                word_idx <= word_idx + 1'b1;
              end else if (loop) begin
                word_idx <= '0;
              end else begin
                state   <= S_DONE;
                start_q <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          if (!play) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/msg_scroller_v2.md
# msg_scroller_v2

Parametrised message scroller for a 7-row column-driven LED/scope display. Message words are written into a circular store, then played back as a stream of 8-bit display columns; each word is either a raw 6-bit column or a character code rendered through the 5x7 glyph ROM. Compared with the first-generation scroller, this block adds:
- a configurable store depth
- a per-column hold prescaler
- loop or one-shot playback
- column-valid and done status
- explicit clear

## Interface
- WORD_COUNT, 20, message store depth in 7-bit words (2..64)
- HOLD_W, 8, width of the column hold prescaler
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write one message word this cycle
- wr_data  in  7  message word: bit6=1 character code in [5:0], bit6=0 raw column in [5:0]
- clear  in  1  empty the store (length to 0)
- play  in  1  level; high requests playback, low aborts or returns to idle
- loop  in  1  sampled at each end of message; 1 restarts, 0 finishes
- hold  in  HOLD_W  each column is held for hold+1 cycles
- col  out  8  current display column, bit0 = top row
- col_valid  out  1  one-cycle pulse on the first cycle of each new column
- busy  out  1  high in PLAY
- done  out  1  high in DONE
- length  out  $clog2(WORD_COUNT+1)  number of stored words

## Operation
- Store: circular buffer of WORD_COUNT words with a write pointer and a length counter.
- wr_en in IDLE writes wr_data at the write pointer and increments length.
  - When the store is full, the write overwrites the oldest word: the oldest pointer advances and length stays at WORD_COUNT.
  - wr_en in PLAY or DONE is ignored.
- clear in IDLE sets length=0 and both pointers to 0. clear has priority over wr_en in the same cycle. clear in PLAY or DONE is ignored.
- States:
  - IDLE -> PLAY when play=1 and length>0.
  - IDLE -> DONE when play=1 and length=0.
  - PLAY -> DONE after the last column of the last word when loop=0.
  - PLAY -> PLAY (restart at the oldest word) after the last column of the last word when loop=1.
  - PLAY or DONE -> IDLE when play=0; this takes priority over every other transition.
- Rendering per word:
  - Raw word (bit6=0): one column slot with col={1'b0, w[5:0], 1'b0}.
  - Character word (bit6=1): 8 column slots, index 0..7, col=glyph(w[5:0], index).
- Glyph ROM uses the team font_5x7 table:
  - codes 0x10-0x19 are '0'-'9'; codes 0x21-0x3A are 'A'-'Z'; all other codes render all-zero columns.
  - Column 0 and column 7 are 0x00 for most glyphs. Wide glyphs (M, W, X, Y, Z, K, Q, T, V) use column 7.
  - Required entries: '0' = 00,3E,61,51,49,45,3E,00; 'A' = 00,7C,12,11,11,12,7C,00.
- Column pacing: the hold counter loads with hold at each new column and decrements to 0; the next column starts on the cycle after it reaches 0. hold is sampled at each column start.
- The stored message is not modified by playback; replaying requires only play to go low and then high again.
- Outside PLAY, col=0x00 and col_valid=0.

## Timing
- Reset (rst_n=0) drives col=0x00, col_valid=0, busy=0, done=0, length=0, and clears pointers, hold counter and glyph index. The FSM goes to IDLE. Stored words are don't-care.
- length updates on the cycle after the accepted write or clear.
- The first column appears in col, with col_valid=1, on the first cycle in PLAY: one clock after play is sampled high in IDLE.
- Each column occupies exactly hold+1 cycles. With hold=0, consecutive columns appear on consecutive cycles with col_valid high every cycle.
- Loop wrap: the first column of the oldest word directly follows the last column of the last word, with no gap cycle.
- One-shot end: done=1 and col=0 on the cycle after the last column's hold expires.
- play low: col=0, busy=0 and done=0 on the next cycle, including mid-column and mid-glyph.
- Reset mid-playback: outputs go to reset values immediately (asynchronously). Playback does not resume after rst_n rises.

## Test plan
- Reset: assert rst_n=0 mid-PLAY -> col=0x00, col_valid=0, busy=0, done=0, length=0 immediately; IDLE after release.
- One-shot: write 0x50 then 0x05, hold=0, loop=0, play=1 -> col sequence 00,3E,61,51,49,45,3E,00,0A with col_valid high each cycle, then done=1 and col=00.
- Hold and loop: write 0x61 ('A'), hold=2, loop=1 -> each of 00,7C,12,11,11,12,7C,00 lasts 3 cycles, with col_valid only on the first; after the last 00 the sequence restarts with 00,7C... and no gap.
- Overwrite: WORD_COUNT=20, write 21 raw words 0x01..0x15 -> length=20; playback starts with column 0x04 (word 0x02) and ends with 0x2A (word 0x15).
- Abort and ignore: drop play mid-glyph -> col=0 and busy=0 next cycle; wr_en during PLAY leaves length unchanged; clear together with wr_en in IDLE -> length=0.
- Empty and unknown code: play with length=0 -> done=1 next cycle and no col_valid; write 0x7F, play -> 8 columns of 0x00 with col_valid pulses.
